// File: rtl/serial_tasizan.sv
// rtl/serial_tasizan.sv - digit-serial adder/subtractor, one DIGIT-bit slice reused N=WIDTH/DIGIT cycles
// Optional signed overflow output compiled in with SERIAL_TASIZAN_OVF_EN.
module serial_tasizan #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SERIAL_TASIZAN_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // Digit sums enter the result register from the top, so after N digits
  // the least-significant digit has walked down to bit 0.
  always_comb begin
    dsum     = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    res_next = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last     = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_TASIZAN_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          opa   <= opa >> DIGIT;
          opb   <= opb >> DIGIT;
          res   <= res_next;
          carry <= dsum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            s     <= res_next;
            cout  <= dsum[DIGIT];
`ifdef SERIAL_TASIZAN_OVF_EN
            // carry into the MSB recovered as a^b^sum at that bit position
            ovf   <= opa[DIGIT-1] ^ opb[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tasizan.sv
// tb/tb_serial_tasizan.sv - directed and randomised checks of serial_tasizan (DIGIT=1, 4, 16)
module tb_serial_tasizan;

  logic        clk = 1'b0;
  logic        rst, start, sub, cin;
  logic [15:0] a, b;
  logic        busy1, done1, cout1, busy4, done4, cout4, busy16, done16, cout16;
  logic [15:0] s1, s4, s16;
`ifdef SERIAL_TASIZAN_OVF_EN
  logic        ovf1, ovf4, ovf16;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_tasizan #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1)
`ifdef SERIAL_TASIZAN_OVF_EN
    , .ovf(ovf1)
`endif
  );

  serial_tasizan #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
`ifdef SERIAL_TASIZAN_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_tasizan #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16)
`ifdef SERIAL_TASIZAN_OVF_EN
    , .ovf(ovf16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // START in cycle t, expect BUSY t+1..t+4 and DONE with result in t+5 (returns in t+5)
  task automatic run_op(input string tag, input logic sb, input logic [15:0] aa, input logic [15:0] bb,
                        input logic ci, input logic [15:0] es, input logic ec, input logic eo);
    sub = sb; a = aa; b = bb; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check({tag, "_busy_phase"}, {30'd0, busy4, done4}, 32'h2);
      tick();
    end
    check({tag, "_done_phase"}, {30'd0, busy4, done4}, 32'h1);
    check({tag, "_s"}, {16'd0, s4}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, cout4}, {31'd0, ec});
`ifdef SERIAL_TASIZAN_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf4}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("unexpected x on overflow expectation in %s", tag);
`endif
  endtask

  initial begin
    logic [16:0] model;
    logic        seen1, seen4, seen16, sdone;
    logic [15:0] ra, rb;
    logic        rc, rs;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("reset_busy_done", {30'd0, busy4, done4}, 32'h0);
    check("reset_s_cout", {15'd0, cout4, s4}, 32'h0);
`ifdef SERIAL_TASIZAN_OVF_EN
    check("reset_ovf", {31'd0, ovf4}, 32'h0);
`endif
    rst = 1'b0;
    tick();

    run_op("add",       1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_op("carry",     1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("carry_cin", 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);
    run_op("sub_neg",   1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_pos",   1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
    run_op("ovf_add",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub",   1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    tick();

    // Ignored START during BUSY, then back-to-back START in the DONE cycle
    sub = 1'b0; a = 16'h0100; b = 16'h0023; cin = 1'b0; start = 1'b1;
    tick();                                   // t+1
    start = 1'b0;
    tick();                                   // t+2
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
    tick();                                   // t+3
    start = 1'b0;
    tick(); tick();                           // t+5
    check("hs_first_done", {31'd0, done4}, 32'h1);
    check("hs_first_s", {16'd0, s4}, 32'h0123);
    sub = 1'b0; a = 16'h4000; b = 16'h4000; cin = 1'b1; start = 1'b1;
    tick();                                   // t+6
    start = 1'b0;
    sdone = 1'b0;
    for (int k = 6; k <= 9; k++) begin
      check("hs_hold_s", {16'd0, s4}, 32'h0123);
      sdone = sdone | done4;
      tick();
    end
    check("hs_no_early_done", {31'd0, sdone}, 32'h0);
    check("hs_second_done", {31'd0, done4}, 32'h1);
    check("hs_second_s_cout", {15'd0, cout4, s4}, 32'h08001);
`ifdef SERIAL_TASIZAN_OVF_EN
    check("hs_second_ovf", {31'd0, ovf4}, 32'h1);
`endif
    tick();

    // Reset mid-operation discards the result and suppresses DONE
    sub = 1'b0; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; start = 1'b1;
    tick();                                   // t+1
    start = 1'b0;
    tick();                                   // t+2
    rst = 1'b1;
    tick();                                   // t+3
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy4}, 32'h0);
    check("rst_mid_s", {16'd0, s4}, 32'h0);
    sdone = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sdone = sdone | done4;
      tick();
    end
    check("rst_mid_no_done", {31'd0, sdone}, 32'h0);

    // Random sweep across the three digit widths against {cout,s} = a + (b or ~b) + (cin ^ sub)
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      model = rs ? ({1'b0, ra} + {1'b0, ~rb} + {16'd0, ~rc})
                 : ({1'b0, ra} + {1'b0, rb} + {16'd0, rc});
      sub = rs; a = ra; b = rb; cin = rc; start = 1'b1;
      tick();
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      seen1 = 1'b0; seen4 = 1'b0; seen16 = 1'b0;
      for (int c = 0; c < 24 && !(seen1 && seen4 && seen16); c++) begin
        if (done1 && !seen1) begin
          check("rnd_d1", {15'd0, cout1, s1}, {15'd0, model});
          seen1 = 1'b1;
        end
        if (done4 && !seen4) begin
          check("rnd_d4", {15'd0, cout4, s4}, {15'd0, model});
          seen4 = 1'b1;
        end
        if (done16 && !seen16) begin
          check("rnd_d16", {15'd0, cout16, s16}, {15'd0, model});
          seen16 = 1'b1;
        end
        if (!(seen1 && seen4 && seen16)) tick();
      end
      check("rnd_done_seen", {29'd0, seen1, seen4, seen16}, 32'h7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
